// File: rtl/freq_meas_sched.sv
// Round-robin frequency meter: one period counter and one external AXI-Stream divider
// shared by P_CH asynchronous test clocks; results in Hz, saturated to 16 bits.
module freq_meas_sched #(
   parameter int unsigned P_CH      = 4,
   parameter logic [31:0] P_CLK     = 32'd100_000_000,
   parameter logic [31:0] P_TIMEOUT = 32'd100_000_000
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_work_en,
   input  logic [P_CH-1:0]           i_test_clk,
   output logic                      o_div_tvalid,
   input  logic                      i_div_tready,
   output logic [31:0]               o_div_divisor,
   output logic [31:0]               o_div_dividend,
   input  logic                      i_div_dvalid,
   input  logic [31:0]               i_div_quot,
   output logic [16*P_CH-1:0]        o_freq,
   output logic [P_CH-1:0]           o_upd,
   output logic [P_CH-1:0]           o_timeout,
   output logic [$clog2(P_CH)-1:0]   o_ch,
   output logic                      o_busy
);

   localparam int unsigned ChW = $clog2(P_CH);

   typedef enum logic [2:0] {StIdle, StWait1, StMeas, StDiv, StDwait, StNext} state_t;

   state_t                 state_q, state_d;
   logic                   en_s1_q, en_s_q;
   logic [P_CH-1:0]        tc_s1_q, tc_s2_q, tc_s3_q;
   logic [31:0]            cnt_q, cnt_d, tmr_q, tmr_d, divisor_q, divisor_d;
   logic [ChW-1:0]         ch_q, ch_d;
   logic [P_CH-1:0][15:0]  freq_q, freq_d;
   logic [P_CH-1:0]        upd_q, upd_d, timeout_q, timeout_d;
   logic                   edge_det, tmo_hit;

   // Synchronisers run on every channel so a newly selected channel has a clean history.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         en_s1_q <= 1'b0;
         en_s_q  <= 1'b0;
         tc_s1_q <= '0;
         tc_s2_q <= '0;
         tc_s3_q <= '0;
      end else begin
         en_s1_q <= i_work_en;
         en_s_q  <= en_s1_q;
         tc_s1_q <= i_test_clk;
         tc_s2_q <= tc_s1_q;
         tc_s3_q <= tc_s2_q;
      end
   end

   assign edge_det = tc_s2_q[ch_q] & ~tc_s3_q[ch_q];
   assign tmo_hit  = (tmr_q == P_TIMEOUT - 32'd1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tmr_d     = tmr_q;
      divisor_d = divisor_q;
      ch_d      = ch_q;
      freq_d    = freq_q;
      upd_d     = '0;
      timeout_d = timeout_q;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            tmr_d = '0;
            if (en_s_q) state_d = StWait1;
         end
         StWait1, StMeas: begin
            tmr_d = tmr_q + 32'd1;
            if (!en_s_q) begin
               tmr_d   = '0;
               cnt_d   = '0;
               state_d = StIdle;
            end else if (edge_det) begin
               // A completing edge beats a timeout landing in the same cycle.
               if (state_q == StWait1) begin
                  cnt_d   = 32'd1;
                  state_d = StMeas;
               end else begin
                  divisor_d = cnt_q;
                  state_d   = StDiv;
               end
            end else if (tmo_hit) begin
               freq_d[ch_q]    = '0;
               timeout_d[ch_q] = 1'b1;
               upd_d[ch_q]     = 1'b1;
               state_d         = StNext;
            end else if (state_q == StMeas) begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         StDiv: begin
            if (i_div_tready) state_d = StDwait;
         end
         StDwait: begin
            if (i_div_dvalid) begin
               freq_d[ch_q]    = (i_div_quot > 32'd65535) ? 16'hFFFF : i_div_quot[15:0];
               timeout_d[ch_q] = 1'b0;
               upd_d[ch_q]     = 1'b1;
               state_d         = StNext;
            end
         end
         StNext: begin
            ch_d    = (ch_q == ChW'(P_CH - 1)) ? '0 : ch_q + 1'b1;
            tmr_d   = '0;
            cnt_d   = '0;
            state_d = en_s_q ? StWait1 : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         tmr_q     <= '0;
         divisor_q <= '0;
         ch_q      <= '0;
         freq_q    <= '0;
         upd_q     <= '0;
         timeout_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tmr_q     <= tmr_d;
         divisor_q <= divisor_d;
         ch_q      <= ch_d;
         freq_q    <= freq_d;
         upd_q     <= upd_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_div_tvalid   = (state_q == StDiv);
   assign o_div_divisor  = divisor_q;
   assign o_div_dividend = P_CLK;
   assign o_freq         = freq_q;
   assign o_upd          = upd_q;
   assign o_timeout      = timeout_q;
   assign o_ch           = ch_q;
   assign o_busy         = (state_q != StIdle);

endmodule
